// File: rtl/wb_regfile_pkg.sv
// Shared CPU definitions for the write-back stage and register file.
package wb_regfile_pkg;
  localparam int DATA_W = 16;
  localparam int NREG   = 16;
  localparam int ADDR_W = 4;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] data_word_t;

  localparam reg_idx_t REG_ZERO = 4'd0;
endpackage

// File: rtl/wb_regfile_array.sv
// Architectural register storage: one synchronous write port, two
// asynchronous read ports, asynchronous clear. R0 always reads as zero.
module regfile_array #(
  parameter int DATA_W = 16,
  parameter int NREG   = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);
  import wb_regfile_pkg::*;

  logic [DATA_W-1:0] regs [NREG];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == ADDR_W'(REG_ZERO)) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == ADDR_W'(REG_ZERO)) ? '0 : regs[raddr2];
endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: result select, write qualification, write-through
// bypass to the decode read ports and a retired-write counter.
module wb_regfile #(
  parameter int DATA_W = 16,
  parameter int NREG   = 16,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic              wb_reg_write,
  input  logic              wb_mem_to_reg,
  input  logic [DATA_W-1:0] wb_mem_data,
  input  logic [DATA_W-1:0] wb_alu_result,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_we,
  output logic [CNT_W-1:0]  retired_cnt
);
  import wb_regfile_pkg::*;

  logic [DATA_W-1:0] arr_rd1;
  logic [DATA_W-1:0] arr_rd2;

  assign wb_data = wb_mem_to_reg ? wb_mem_data : wb_alu_result;
  // Gating with reset keeps the bypass silent while the array is held clear.
  assign wb_we   = wb_valid & wb_reg_write & (wb_rd != ADDR_W'(REG_ZERO)) & ~reset;

  regfile_array #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk    (clk),
    .reset  (reset),
    .we     (wb_we),
    .waddr  (wb_rd),
    .wdata  (wb_data),
    .raddr1 (rs1_addr),
    .raddr2 (rs2_addr),
    .rdata1 (arr_rd1),
    .rdata2 (arr_rd2)
  );

  // wb_we already excludes R0, so the bypass can never expose an R0 write.
  assign rs1_data = (wb_we && (rs1_addr == wb_rd)) ? wb_data : arr_rd1;
  assign rs2_data = (wb_we && (rs2_addr == wb_rd)) ? wb_data : arr_rd2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_cnt <= '0;
    end else if (wb_we) begin
      retired_cnt <= retired_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile (counter narrowed to 4 bits to reach wrap quickly).
module tb_wb_regfile;
  localparam int CNT_W = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wb_valid = 1'b0, wb_reg_write = 1'b0, wb_mem_to_reg = 1'b0;
  logic [15:0] wb_mem_data = '0, wb_alu_result = '0;
  logic [3:0]  wb_rd = '0, rs1_addr = '0, rs2_addr = '0;
  logic [15:0] rs1_data, rs2_data, wb_data;
  logic        wb_we;
  logic [CNT_W-1:0] retired_cnt;

  wb_regfile #(.DATA_W(16), .NREG(16), .ADDR_W(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_mem_data(wb_mem_data),
    .wb_alu_result(wb_alu_result), .wb_rd(wb_rd), .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_data(wb_data), .wb_we(wb_we), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          sel;
    string       tag;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t   sb [$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] mregs [16];
  int          mcnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0:       return {16'h0, rs1_data};
      1:       return {16'h0, rs2_data};
      2:       return {16'h0, wb_data};
      3:       return {31'h0, wb_we};
      default: return {{(32-CNT_W){1'b0}}, retired_cnt};
    endcase
  endfunction

  task automatic push(input int sel, input string tag, input logic [31:0] exp);
    sb_entry_t e;
    e.sel = sel; e.tag = tag; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    sb_entry_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.sel), e.exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp();
    return 32'(mcnt % (1 << CNT_W));
  endfunction

  // Called one time unit after a rising edge; returns one unit after the next.
  task automatic cycle(input logic v, input logic rw, input logic m2r,
                       input logic [15:0] mem, input logic [15:0] alu,
                       input logic [3:0] rd, input logic [3:0] a1, input logic [3:0] a2);
    logic        we;
    logic [15:0] wd;
    wb_valid = v; wb_reg_write = rw; wb_mem_to_reg = m2r;
    wb_mem_data = mem; wb_alu_result = alu; wb_rd = rd;
    rs1_addr = a1; rs2_addr = a2;
    we = v & rw & (rd != 4'd0);
    wd = m2r ? mem : alu;
    push(0, "rs1_data", {16'h0, (a1 == 4'd0) ? 16'h0 : ((we && a1 == rd) ? wd : mregs[a1])});
    push(1, "rs2_data", {16'h0, (a2 == 4'd0) ? 16'h0 : ((we && a2 == rd) ? wd : mregs[a2])});
    push(2, "wb_data", {16'h0, wd});
    push(3, "wb_we", {31'h0, we});
    push(4, "retired_cnt", cnt_exp());
    #3;
    drain();
    @(posedge clk);
    if (we) begin
      mregs[rd] = wd;
      mcnt++;
    end
    #1;
  endtask

  task automatic bubble_read(input logic [3:0] a1, input logic [3:0] a2);
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 4'd0, a1, a2);
  endtask

  task automatic check_all_zero_under_reset();
    for (int i = 0; i < 16; i++) begin
      rs1_addr = 4'(i); rs2_addr = 4'(15 - i);
      #1;
      push(0, "rst_rs1", 32'h0);
      push(1, "rst_rs2", 32'h0);
      drain();
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mregs[i] = 16'h0;

    // Reset with a pending write to R3 on the inputs.
    wb_valid = 1'b1; wb_reg_write = 1'b1; wb_mem_to_reg = 1'b0;
    wb_alu_result = 16'h1234; wb_rd = 4'd3;
    #1 reset = 1'b1;
    #1;
    push(3, "rst_wb_we", 32'h0);
    push(4, "rst_cnt", 32'h0);
    push(2, "rst_wb_data", 32'h1234);
    drain();
    check_all_zero_under_reset();
    wb_valid = 1'b0; wb_reg_write = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    bubble_read(4'd3, 4'd3);

    // Basic commit via ALU then load path.
    cycle(1'b1, 1'b1, 1'b0, 16'h5555, 16'hBEEF, 4'd5, 4'd1, 4'd2);
    cycle(1'b1, 1'b1, 1'b1, 16'hCAFE, 16'h3333, 4'd6, 4'd5, 4'd0);
    bubble_read(4'd5, 4'd6);

    // Bypass on both ports, then no bypass for a bubble.
    cycle(1'b1, 1'b1, 1'b0, 16'h0, 16'h00A5, 4'd7, 4'd7, 4'd7);
    cycle(1'b0, 1'b1, 1'b0, 16'h0, 16'h1111, 4'd7, 4'd7, 4'd6);
    // Valid but not writing: no bypass either.
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 16'h2222, 4'd7, 4'd7, 4'd5);

    // R0 writes are discarded and do not count.
    cycle(1'b1, 1'b1, 1'b0, 16'h0, 16'hFFFF, 4'd0, 4'd0, 4'd0);
    bubble_read(4'd0, 4'd7);

    // Back-to-back writes to one register: last write wins.
    cycle(1'b1, 1'b1, 1'b0, 16'h0, 16'h0A0A, 4'd9, 4'd9, 4'd1);
    cycle(1'b1, 1'b1, 1'b1, 16'hB0B0, 16'h0, 4'd9, 4'd9, 4'd9);
    bubble_read(4'd9, 4'd9);

    // Random traffic.
    for (int n = 0; n < 60; n++) begin
      cycle(1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
            4'($urandom), 4'($urandom), 4'($urandom));
    end

    // Counter wrap: bring to 0xE, then two more commits give 0xF and 0x0.
    while ((mcnt % 16) != 14)
      cycle(1'b1, 1'b1, 1'b0, 16'h0, 16'($urandom), 4'd8, 4'd8, 4'd0);
    bubble_read(4'd8, 4'd0);
    cycle(1'b1, 1'b1, 1'b0, 16'h0, 16'h0E0E, 4'd10, 4'd10, 4'd0);
    cycle(1'b1, 1'b1, 1'b0, 16'h0, 16'h0F0F, 4'd11, 4'd10, 4'd11);
    bubble_read(4'd10, 4'd11);

    // Reset asserted between edges during back-to-back writes.
    cycle(1'b1, 1'b1, 1'b0, 16'h0, 16'h0001, 4'd1, 4'd1, 4'd0);
    wb_valid = 1'b1; wb_reg_write = 1'b1; wb_mem_to_reg = 1'b0;
    wb_alu_result = 16'h0002; wb_rd = 4'd2;
    #2 reset = 1'b1;
    for (int i = 0; i < 16; i++) mregs[i] = 16'h0;
    mcnt = 0;
    #1;
    push(3, "midrst_wb_we", 32'h0);
    push(4, "midrst_cnt", 32'h0);
    push(2, "midrst_wb_data", 32'h0002);
    drain();
    check_all_zero_under_reset();
    wb_valid = 1'b0; wb_reg_write = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    bubble_read(4'd1, 4'd2);

    // Normal commit resumes after reset.
    cycle(1'b1, 1'b1, 1'b1, 16'h4444, 16'h0, 4'd4, 4'd4, 4'd1);
    bubble_read(4'd4, 4'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running, expected done");
    $fatal(1);
  end
endmodule
